// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_scan_ctrl_pkg;

   localparam int unsigned BCD_W      = 4;
   localparam int unsigned MAX_DIGITS = 8;

   // All-ones select turns every digit off; slice to the instance width.
   localparam logic [MAX_DIGITS-1:0] SEL_BLANK = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_timer.sv
// scan_timer: loadable down-counter that holds at zero; tc_c flags the zero count.
module scan_timer #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc_c
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tc_c = (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit-multiplexed display scanner with a shadow buffer published only at frame boundaries.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int unsigned N_DIGITS  = 8,
   parameter int unsigned DWELL_CYC = 50000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                lz_en,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [2:0]          wr_idx,
   input  logic [BCD_W-1:0]    wr_data,
   input  logic                commit,
   output logic                commit_pend,
   output logic [BCD_W-1:0]    bcd,
   output logic [N_DIGITS-1:0] dig_n,
   output logic                frame_done
);

   localparam int unsigned MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int unsigned TMR_W   = $clog2(MAX_CYC);
   localparam int unsigned CNT_W   = $clog2(N_DIGITS);

   localparam logic [N_DIGITS-1:0] DIG_OFF = SEL_BLANK[N_DIGITS-1:0];

   scan_state_t                          state, state_d;
   logic [CNT_W-1:0]                     dig, dig_d;
   logic [N_DIGITS-1:0][BCD_W-1:0]       shadow, disp;
   logic [N_DIGITS-1:0]                  dig_n_d, supp_c;
   logic [BCD_W-1:0]                     bcd_d;
   logic                                 fd_d, pend_d;
   logic                                 tmr_load, tmr_tc_c;
   logic [TMR_W-1:0]                     tmr_val;
   logic                                 wr_acc_c, commit_acc_c, swap_c, wr_in_range_c;

   scan_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc_c     (tmr_tc_c)
   );

   // Leading-zero mask: a digit is suppressed when it and everything above it is zero.
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      supp_c   = '0;
      for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
         zero_run  = zero_run & (disp[i] == '0);
         supp_c[i] = lz_en & zero_run;
      end
   end

   // Next-state, timer control and next output values.
   always_comb begin
      state_d  = state;
      dig_d    = dig;
      tmr_load = 1'b0;
      tmr_val  = '0;
      fd_d     = 1'b0;
      dig_n_d  = DIG_OFF;
      bcd_d    = '0;

      if (!en) begin
         state_d  = ST_IDLE;
         dig_d    = '0;
         tmr_load = 1'b1;
      end else begin
         unique case (state)
            ST_IDLE: begin
               state_d  = ST_BLANK;
               tmr_load = 1'b1;
               tmr_val  = TMR_W'(BLANK_CYC - 1);
            end
            ST_BLANK: begin
               if (tmr_tc_c) begin
                  state_d  = ST_SHOW;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(DWELL_CYC - 1);
               end
            end
            ST_SHOW: begin
               if (tmr_tc_c) begin
                  state_d  = ST_BLANK;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(BLANK_CYC - 1);
                  if (dig == CNT_W'(N_DIGITS - 1)) begin
                     dig_d = '0;
                     fd_d  = 1'b1;
                  end else begin
                     dig_d = dig + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d  = ST_IDLE;
               dig_d    = '0;
               tmr_load = 1'b1;
            end
         endcase
      end

      // SHOW never starts on a swap edge, so the current display is the one to show.
      if (state_d == ST_SHOW) begin
         bcd_d = disp[dig_d];
         if (disp[dig_d] <= BCD_W'(9) && !supp_c[dig_d]) begin
            dig_n_d[dig_d] = 1'b0;
         end
      end
   end

   assign wr_in_range_c = (32'(wr_idx) < N_DIGITS);
   assign wr_acc_c      = wr_valid & ~commit_pend & wr_in_range_c;
   assign commit_acc_c  = commit & ~commit_pend;
   assign swap_c        = commit_pend & ((state == ST_IDLE) | fd_d);

   always_comb begin
      pend_d = commit_pend;
      if (swap_c) begin
         pend_d = 1'b0;
      end else if (commit_acc_c) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         dig         <= '0;
         shadow      <= '0;
         disp        <= '0;
         dig_n       <= DIG_OFF;
         bcd         <= '0;
         frame_done  <= 1'b0;
         commit_pend <= 1'b0;
         wr_ready    <= 1'b1;
      end else begin
         state       <= state_d;
         dig         <= dig_d;
         dig_n       <= dig_n_d;
         bcd         <= bcd_d;
         frame_done  <= fd_d;
         commit_pend <= pend_d;
         wr_ready    <= ~pend_d;
         if (wr_acc_c) begin
            shadow[wr_idx[CNT_W-1:0]] <= wr_data;
         end
         if (swap_c) begin
            disp <= shadow;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int BK = 2;
   localparam int SL = BK + DW;
   localparam int FR = N * SL;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         en, lz_en, wr_valid, wr_ready, commit, commit_pend, frame_done;
   logic [2:0]   wr_idx;
   logic [3:0]   wr_data, bcd;
   logic [N-1:0] dig_n;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: frame position counter plus buffers.
   int m_disp[N];
   int m_shad[N];
   bit m_pend, m_idle, m_fd, m_lz;
   int m_pos;

   seg_scan_ctrl #(.N_DIGITS(N), .DWELL_CYC(DW), .BLANK_CYC(BK)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .lz_en       (lz_en),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .commit      (commit),
      .commit_pend (commit_pend),
      .bcd         (bcd),
      .dig_n       (dig_n),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_disp[i] = 0;
         m_shad[i] = 0;
      end
      m_pend = 0; m_idle = 1; m_fd = 0; m_lz = 0; m_pos = 0;
   endtask

   task automatic model_outputs(output logic [N-1:0] edn, output logic [3:0] ebcd);
      int slot;
      bit vis, allz;
      edn  = '1;
      ebcd = '0;
      if (!m_idle && (m_pos % SL) >= BK) begin
         slot = m_pos / SL;
         ebcd = 4'(m_disp[slot]);
         vis  = (m_disp[slot] <= 9);
         if (m_lz && slot > 0) begin
            allz = 1;
            for (int j = slot; j < N; j++) if (m_disp[j] != 0) allz = 0;
            if (allz) vis = 0;
         end
         if (vis) edn[slot] = 1'b0;
      end
   endtask

   // One clock: drive at negedge, advance model, sample 1 time unit after posedge.
   task automatic cycle(input bit e, input bit lz, input bit wv, input logic [2:0] wi,
                        input logic [3:0] wd, input bit cm);
      bit was_idle, acc;
      logic [N-1:0] edn;
      logic [3:0] ebcd;
      en = e; lz_en = lz; wr_valid = wv; wr_idx = wi; wr_data = wd; commit = cm;
      was_idle = m_idle;
      if (wv && !m_pend && int'(wi) < N) m_shad[wi] = int'(wd);
      acc  = cm && !m_pend;
      m_fd = 0;
      if (!e) begin
         m_idle = 1;
      end else if (m_idle) begin
         m_idle = 0;
         m_pos  = 0;
      end else begin
         m_pos++;
         if (m_pos == FR) begin
            m_pos = 0;
            m_fd  = 1;
         end
      end
      if (m_pend && (was_idle || m_fd)) begin
         m_disp = m_shad;
         m_pend = 0;
      end
      if (acc) m_pend = 1;
      m_lz = lz;
      model_outputs(edn, ebcd);
      @(posedge clk);
      #1;
      check("dig_n", 32'(dig_n), 32'(edn));
      check("bcd", 32'(bcd), 32'(ebcd));
      check("frame_done", 32'(frame_done), 32'(m_fd));
      check("commit_pend", 32'(commit_pend), 32'(m_pend));
      check("wr_ready", 32'(wr_ready), 32'(!m_pend));
      @(negedge clk);
   endtask

   task automatic idle_cycles(input bit e, input bit lz, input int n);
      for (int i = 0; i < n; i++) cycle(e, lz, 1'b0, 3'd0, 4'd0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_dig_n"}, 32'(dig_n), 32'(4'hF));
      check({tag, "_bcd"}, 32'(bcd), 32'd0);
      check({tag, "_fd"}, 32'(frame_done), 32'd0);
      check({tag, "_pend"}, 32'(commit_pend), 32'd0);
      check({tag, "_ready"}, 32'(wr_ready), 32'd1);
   endtask

   initial begin
      int guard;
      bit e, lz;
      rst_n = 1'b0; en = 0; lz_en = 0; wr_valid = 0; wr_idx = 0; wr_data = 0; commit = 0;
      model_reset();
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Load 1,2,3,4, publish from idle, then scan two frames.
      for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, 1'b1, 3'(i), 4'(i + 1), 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
      idle_cycles(1'b0, 1'b0, 1);
      idle_cycles(1'b1, 1'b0, 2 * FR + 3);

      // Mid-frame write plus commit; a blocked write while pending is dropped.
      idle_cycles(1'b1, 1'b0, 5);
      cycle(1'b1, 1'b0, 1'b1, 3'd0, 4'd7, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 3'd1, 4'd9, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1);
      idle_cycles(1'b1, 1'b0, 2 * FR);

      // 0,0,5,0 with leading-zero suppression, then digit 1 set to 12.
      cycle(1'b1, 1'b1, 1'b1, 3'd3, 4'd0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 3'd2, 4'd5, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 3'd1, 4'd0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 3'd0, 4'd0, 1'b1);
      idle_cycles(1'b1, 1'b1, 2 * FR);
      cycle(1'b1, 1'b1, 1'b1, 3'd1, 4'd12, 1'b1);
      idle_cycles(1'b1, 1'b1, 2 * FR);

      // Drop enable in the middle of digit 2's slot, then restart.
      guard = 0;
      while (!(!m_idle && m_pos == 2 * SL + BK + 1) && guard < 4 * FR) begin
         idle_cycles(1'b1, 1'b0, 1);
         guard++;
      end
      check("reach_digit2", 32'(guard < 4 * FR), 32'd1);
      idle_cycles(1'b0, 1'b0, 3);
      idle_cycles(1'b1, 1'b0, FR + 4);

      // Randomised traffic.
      lz = 0;
      for (int k = 0; k < 3000; k++) begin
         e = ($urandom_range(99) != 0);
         if ($urandom_range(49) == 0) lz = ~lz;
         cycle(e, lz, ($urandom_range(3) == 0), 3'($urandom_range(7)),
               4'($urandom_range(15)), ($urandom_range(19) == 0));
      end

      // Asynchronous reset mid-frame with a commit pending.
      idle_cycles(1'b1, 1'b0, 7);
      cycle(1'b1, 1'b0, 1'b1, 3'd2, 4'd8, 1'b1);
      idle_cycles(1'b1, 1'b0, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(1'b1, 1'b0, FR + 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed digits (2..8).
REQ-002 Parameter DWELL_CYC, default 50000, clock cycles one digit is driven per scan slot (>=2).
REQ-003 Parameter BLANK_CYC, default 500, clock cycles all digits are off between slots to prevent ghosting (>=1).
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  scan enable; low forces the blanked idle state.
REQ-007 lz_en  input  1  leading-zero suppression enable.
REQ-008 wr_valid  input  1  shadow-buffer write request.
REQ-009 wr_ready  output  1  write accepted when wr_valid and wr_ready are both high.
REQ-010 wr_idx  input  3  digit index to write (0 = rightmost).
REQ-011 wr_data  input  4  BCD value to write.
REQ-012 commit  input  1  single-cycle request to publish the shadow buffer to the display at the next frame boundary.
REQ-013 commit_pend  output  1  high from an accepted commit until the swap occurs.
REQ-014 bcd  output  4  value routed to the shared 4-to-7 segment decoder.
REQ-015 dig_n  output  N_DIGITS  one-hot-low digit select; all ones = blank.
REQ-016 frame_done  output  1  one-cycle pulse when the last digit's slot ends.

Function
REQ-017 The FSM SHALL have states IDLE, BLANK and SHOW.
REQ-018 IDLE: dig_n all ones, digit counter 0, timers 0; leave to BLANK when en=1.
REQ-019 BLANK: dig_n all ones for exactly BLANK_CYC cycles, then SHOW.
REQ-020 SHOW: dig_n bit[digit counter]=0 for exactly DWELL_CYC cycles, then BLANK with the digit counter incremented.
REQ-021 The digit counter SHALL wrap from N_DIGITS-1 to 0; frame_done pulses in the cycle the SHOW of digit N_DIGITS-1 ends.
REQ-022 en=0 in any state SHALL move to IDLE on the next edge, abandoning the frame without a frame_done pulse.
REQ-023 bcd SHALL equal the display register of the current digit in SHOW and 0 otherwise; bcd and dig_n are registered and change in the same cycle.
REQ-024 A display value >9 SHALL keep that digit's dig_n bit high (blank) for its slot; timing is unchanged.
REQ-025 With lz_en=1, any digit above index 0 whose value and all higher-index values are 0 SHALL be blanked; digit 0 is never suppressed.
REQ-026 wr_ready SHALL be high whenever commit_pend=0; accepted writes update only the shadow buffer; wr_idx >= N_DIGITS is accepted and discarded.
REQ-027 commit is accepted only when commit_pend=0; when commit_pend=1 it is ignored.
REQ-028 The shadow-to-display copy SHALL occur in the frame_done cycle, or in the cycle after acceptance if the FSM is in IDLE; commit_pend clears in the same cycle.
REQ-029 A write and a commit in the same cycle SHALL both be accepted, and the write SHALL be included in the published frame.
REQ-030 A display change SHALL take effect only at a frame boundary, so no frame mixes old and new data.

Reset
REQ-031 Reset SHALL force IDLE, digit counter 0, timers 0, shadow and display registers 0, dig_n all ones, bcd 0, frame_done 0, commit_pend 0, and wr_ready 1.
REQ-032 Reset asserted mid-frame or with a commit pending SHALL discard the pending commit with no partial swap.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the BCD width constant (4), and the blank code (all-ones select).
REQ-034 The dwell and blank timer SHALL be one sub-module, scan_timer: loadable down-counter with a terminal-count output.
REQ-035 The segment decoder SHALL remain outside this block; this block drives only bcd and dig_n.

Verification (N_DIGITS=4, DWELL_CYC=4, BLANK_CYC=2)
REQ-036 Reset, write 1,2,3,4 to idx0..3, commit, en=1 -> commit_pend clears within 1 cycle; dig_n sequence 1111x2, 1110x4 with bcd=1, 1111x2, 1101x4 with bcd=2, and so on; frame_done every 24 cycles.
REQ-037 Write idx0=7 mid-frame and commit -> the displayed value changes only after the next frame_done; commit_pend is high until then and wr_ready is low while it is high.
REQ-038 Display 0,0,5,0 (idx3..0) with lz_en=1 -> idx3 blanked, idx2 shows 5, idx1 shows 0, idx0 shows 0.
REQ-039 Write idx1=12 -> digit 1's slot has dig_n=1111 for 4 cycles while frame timing is unchanged.
REQ-040 Drop en during SHOW of digit 2 -> the next cycle is IDLE with dig_n=1111 and no frame_done; re-enabling restarts at digit 0 with BLANK.
REQ-041 Assert rst_n low with commit pending mid-frame -> all outputs reach reset values asynchronously and the display registers read 0.
